mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified memory port of risc_v_pineline between the instruction-fetch (IF) and
//   data-memory (DM) stages. One transaction is outstanding at a time. DM has priority, and an
//   anti-starvation counter protects IF. Grant/valid pulses drive the pipeline stall/hazard logic.
//   IF flush (branch redirect) discards an in-flight fetch response.
// PARAMETERS
//   ADDR_W      32  address width, all ports
//   DATA_W      32  data width; byte enables are DATA_W/8
//   STARVE_MAX  4   IF-pending-not-granted cycles before IF overrides DM priority (>=1)
// PORTS
//   clk           in   1          clock, all logic on rising edge
//   reset         in   1          synchronous, active-high
//   if_req        in   1          fetch request; held with if_addr until if_gnt
//   if_addr       in   ADDR_W     fetch address
//   if_flush      in   1          drop any granted-but-unreturned fetch
//   if_gnt        out  1          1-cycle pulse: fetch captured
//   if_rvalid     out  1          1-cycle pulse: if_rdata valid
//   if_rdata      out  DATA_W     fetch data
//   dm_req        in   1          data request; held with payload until dm_gnt
//   dm_we         in   1          1 = write
//   dm_be         in   DATA_W/8   byte enables (write)
//   dm_addr       in   ADDR_W     data address
//   dm_wdata      in   DATA_W     write data
//   dm_gnt        out  1          1-cycle pulse: data request captured
//   dm_rvalid     out  1          1-cycle pulse: load data / store ack
//   dm_rdata      out  DATA_W     load data (don't-care on store ack)
//   mem_req       out  1          registered request to memory
//   mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered payload
//   mem_ready     in   1          memory accepts request this cycle
//   mem_rvalid    in   1          memory response (reads and writes)
//   mem_rdata     in   DATA_W     memory read data
//   protocol_err  out  1          sticky: mem_rvalid outside an active transaction
// BEHAVIOUR
//   States: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
//   Reset:
//     - state=IDLE.
//     - All outputs 0, starve count 0, flush_pend 0.
//     - Reset mid-transaction abandons it silently; memory shares the same reset.
//   IDLE arbitration (combinational gnt, same cycle):
//     - DM wins if dm_req && !(if_req && starve==STARVE_MAX).
//     - Otherwise IF wins if if_req.
//     - Winner: gnt=1; payload latched into mem_*; mem_req=1 next cycle; ->REQ_x.
//     - IF payload: mem_we=0, mem_be=all ones.
//   REQ_x:
//     - mem_req and payload held stable until mem_ready=1.
//     - mem_ready=1: mem_req=0 next cycle; ->WAIT_x.
//     - mem_ready && mem_rvalid in the same cycle: complete directly, ->IDLE.
//   WAIT_x: on mem_rvalid, ->IDLE.
//   Response routing:
//     - x_rvalid = mem_rvalid && state in {REQ_x (with ready), WAIT_x}.
//     - rdata = mem_rdata, combinational.
//   Latency: gnt at cycle t, mem_req high t+1, earliest rvalid t+1. Next gnt at completion+1.
//   Starve counter:
//     - +1 (saturating at STARVE_MAX) each IDLE cycle with if_req && !if_gnt.
//     - Also +1 each non-IDLE cycle with if_req.
//     - Cleared on if_gnt.
//   Flush:
//     - if_flush in REQ_I/WAIT_I sets flush_pend; the response is consumed, if_rvalid forced 0.
//     - flush_pend clears on return to IDLE.
//     - if_flush in IDLE, or in the gnt cycle, cancels nothing; the pipeline deasserts if_req.
//     - if_flush in the same cycle as mem_rvalid in WAIT_I suppresses that if_rvalid.
//   Error: mem_rvalid in IDLE, or in REQ_x without mem_ready, sets protocol_err (cleared only by
//     reset). The response is ignored.
//   Ordering: requests in the two address ranges are not coherency-tracked; IF/DM ordering is the
//     pipeline's responsibility.
// STRUCTURE
//   Package mem_arb_pkg:
//     - typedef enum logic [2:0] arb_state_t {IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D}.
//     - typedef enum logic {SRC_IF, SRC_DM} arb_src_t.
//   Sub-module arb_starve_ctr (saturating counter: inc, clr, sat output; parameter MAX).
//   Top: FSM, payload regs, response mux, flush/err flags.
// TESTING
//   1 Lone IF read addr 0x100, mem_ready at t+1, rvalid at t+3 with 0xDEADBEEF
//     -> if_gnt@t, if_rvalid@t+3, if_rdata=0xDEADBEEF.
//   2 if_req and dm_req (store 0x200, be=4'b0011) both high in IDLE
//     -> dm_gnt first, mem_we=1, mem_be=0011; if_gnt at completion+1.
//   3 dm_req held high continuously with if_req, STARVE_MAX=4
//     -> if_gnt no later than the 5th arbitration slot; counter clears.
//   4 if_flush during WAIT_I, then mem_rvalid
//     -> if_rvalid stays 0; next fetch grant proceeds normally.
//   5 mem_ready held 0 for 10 cycles -> mem_req/mem_addr stable throughout; no duplicate gnt.
//   6 Unsolicited mem_rvalid in IDLE -> protocol_err=1 and stays 1; reset mid-WAIT_D -> all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the IF/DM memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D} arb_state_t;
    typedef enum logic {SRC_IF, SRC_DM} arb_src_t;

    function automatic logic is_if_state(input arb_state_t s);
        return (s == REQ_I) || (s == WAIT_I);
    endfunction

    function automatic logic is_dm_state(input arb_state_t s);
        return (s == REQ_D) || (s == WAIT_D);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating counter of cycles a fetch waited without a grant
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                protocol_err
);

    arb_state_t state, state_next;
    arb_src_t   src;
    logic       starve_sat;
    logic       flush_pend;
    logic       resp_ok;
    logic       err_set;

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (if_req && !if_gnt),
        .clr   (if_gnt),
        .sat   (starve_sat)
    );

    always_comb begin
        state_next = state;
        src        = SRC_IF;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                err_set = mem_rvalid;
                if (dm_req && !(if_req && starve_sat)) begin
                    dm_gnt     = 1'b1;
                    src        = SRC_DM;
                    state_next = REQ_D;
                end else if (if_req) begin
                    if_gnt     = 1'b1;
                    state_next = REQ_I;
                end
            end
            REQ_I: begin
                if (mem_ready) state_next = mem_rvalid ? IDLE : WAIT_I;
                else           err_set    = mem_rvalid;
            end
            REQ_D: begin
                if (mem_ready) state_next = mem_rvalid ? IDLE : WAIT_D;
                else           err_set    = mem_rvalid;
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // a response only belongs to us once the request was accepted
        resp_ok = mem_rvalid &&
                  ((mem_ready && (state == REQ_I || state == REQ_D)) ||
                   state == WAIT_I || state == WAIT_D);
        if_rvalid = resp_ok && is_if_state(state) && !flush_pend && !if_flush;
        dm_rvalid = resp_ok && is_dm_state(state);

        if (reset) begin
            if_gnt    = 1'b0;
            dm_gnt    = 1'b0;
            if_rvalid = 1'b0;
            dm_rvalid = 1'b0;
        end
    end

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            flush_pend   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next == REQ_I) || (state_next == REQ_D);
            if (if_gnt || dm_gnt) begin
                if (src == SRC_DM) begin
                    mem_we    <= dm_we;
                    mem_be    <= dm_be;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_be    <= '1;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end
            end
            if (state_next == IDLE) begin
                flush_pend <= 1'b0;
            end else if (if_flush && is_if_state(state)) begin
                flush_pend <= 1'b1;
            end
            if (err_set) protocol_err <= 1'b1;
        end
    end

endmodule
